// File: rtl/bless_port_alloc.sv
// bless_port_alloc: oldest-first port allocator and xbar control sequencer for a BLESS deflection router
module bless_port_alloc #(
    parameter int NUM_CH     = 4,
    parameter int IDX_W      = 2,
    parameter int AGE_W      = 8,
    parameter int STARVE_MAX = 16,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] vld_in,
    input  logic [NUM_CH-1:0] ppv_in_0,
    input  logic [NUM_CH-1:0] ppv_in_1,
    input  logic [NUM_CH-1:0] ppv_in_2,
    input  logic [NUM_CH-1:0] ppv_in_3,
    input  logic [AGE_W-1:0]  age_in_0,
    input  logic [AGE_W-1:0]  age_in_1,
    input  logic [AGE_W-1:0]  age_in_2,
    input  logic [AGE_W-1:0]  age_in_3,
    input  logic              inj_req,
    input  logic [NUM_CH-1:0] inj_ppv,
    output logic              inj_gnt,
    output logic [IDX_W-1:0]  inj_slot,
    output logic [IDX_W-1:0]  indir_rank0,
    output logic [IDX_W-1:0]  indir_rank1,
    output logic [IDX_W-1:0]  indir_rank2,
    output logic [IDX_W-1:0]  indir_rank3,
    output logic [NUM_CH-1:0] allocPV_0,
    output logic [NUM_CH-1:0] allocPV_1,
    output logic [NUM_CH-1:0] allocPV_2,
    output logic [NUM_CH-1:0] allocPV_3,
    output logic [NUM_CH-1:0] vld_out,
    output logic [CNT_W-1:0]  defl_cnt,
    output logic              starve
);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam int KEY_W = 1 + AGE_W + IDX_W;

    logic [NUM_CH-1:0] ppv [NUM_CH];
    logic [NUM_CH-1:0] eppv [NUM_CH];
    logic [AGE_W-1:0]  age [NUM_CH];
    logic [KEY_W-1:0]  key [NUM_CH];
    logic [IDX_W-1:0]  rank [NUM_CH];
    logic [IDX_W-1:0]  order [NUM_CH];
    logic [IDX_W-1:0]  order_q [NUM_CH];
    logic [NUM_CH-1:0] alloc [NUM_CH];
    logic [NUM_CH-1:0] alloc_q [NUM_CH];
    logic [NUM_CH-1:0] ev, free, prod, pick;
    logic [IDX_W-1:0]  rr_ptr;
    logic [2:0]        ndefl;
    logic [CNT_W:0]    defl_sum;
    logic [SC_W-1:0]   starve_cnt;

    assign inj_gnt  = !reset && inj_req && !(&vld_in);
    assign inj_slot = !vld_in[0] ? IDX_W'(0) : !vld_in[1] ? IDX_W'(1) : !vld_in[2] ? IDX_W'(2) : IDX_W'(3);

    // The injected flit joins the datapath as an age-0 flit in the granted slot.
    always_comb begin
        ppv = '{ppv_in_0, ppv_in_1, ppv_in_2, ppv_in_3};
        age = '{age_in_0, age_in_1, age_in_2, age_in_3};
        ev  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ev[c]   = vld_in[c] | (inj_gnt && inj_slot == IDX_W'(c));
            eppv[c] = vld_in[c] ? ppv[c] : inj_ppv;
            key[c]  = {ev[c], vld_in[c] ? age[c] : AGE_W'(0), ~(IDX_W'(c) - rr_ptr)};
        end
    end

    // Keys are unique (rotated index in the LSBs), so rank is a strict count of winners.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            rank[c] = '0;
            for (int j = 0; j < NUM_CH; j++)
                if (key[j] > key[c]) rank[c] = rank[c] + IDX_W'(1);
        end
        for (int k = 0; k < NUM_CH; k++) begin
            order[k] = '0;
            for (int c = 0; c < NUM_CH; c++)
                if (rank[c] == IDX_W'(k)) order[k] = IDX_W'(c);
        end
    end

    always_comb begin
        free  = '1;
        ndefl = '0;
        prod  = '0;
        pick  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            prod     = eppv[order[k]] & free;
            pick     = (prod != '0) ? prod : free;
            alloc[k] = ev[order[k]] ? (pick & (~pick + NUM_CH'(1))) : '0;
            ndefl    = ndefl + 3'(ev[order[k]] && prod == '0);
            free     = free & ~alloc[k];
        end
    end

    assign defl_sum = {1'b0, defl_cnt} + (CNT_W + 1)'(ndefl);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                order_q[k] <= IDX_W'(k);
                alloc_q[k] <= '0;
            end
            vld_out    <= '0;
            defl_cnt   <= '0;
            rr_ptr     <= '0;
            starve_cnt <= '0;
        end else begin
            order_q    <= order;
            alloc_q    <= alloc;
            vld_out    <= ~free;
            defl_cnt   <= defl_sum[CNT_W] ? '1 : defl_sum[CNT_W-1:0];
            rr_ptr     <= rr_ptr + IDX_W'(|ev);
            starve_cnt <= (inj_req && !inj_gnt) ? ((starve_cnt == SC_W'(STARVE_MAX)) ? starve_cnt : starve_cnt + SC_W'(1)) : '0;
        end
    end

    assign starve      = starve_cnt >= SC_W'(STARVE_MAX);
    assign indir_rank0 = order_q[0];
    assign indir_rank1 = order_q[1];
    assign indir_rank2 = order_q[2];
    assign indir_rank3 = order_q[3];
    assign allocPV_0   = alloc_q[0];
    assign allocPV_1   = alloc_q[1];
    assign allocPV_2   = alloc_q[2];
    assign allocPV_3   = alloc_q[3];
endmodule

// File: tb/tb_bless_port_alloc.sv
// tb_bless_port_alloc: scoreboard bench for the BLESS port allocator
module tb_bless_port_alloc;
    logic clk = 1'b0;
    logic reset;
    logic [3:0] vld_in, ppv_in_0, ppv_in_1, ppv_in_2, ppv_in_3, inj_ppv;
    logic [7:0] age_in_0, age_in_1, age_in_2, age_in_3;
    logic inj_req, inj_gnt, starve;
    logic [1:0] inj_slot, indir_rank0, indir_rank1, indir_rank2, indir_rank3;
    logic [3:0] allocPV_0, allocPV_1, allocPV_2, allocPV_3, vld_out;
    logic [15:0] defl_cnt;

    typedef struct packed {
        logic [7:0]  ranks;
        logic [15:0] allocs;
        logic [3:0]  vo;
        logic [15:0] defl;
        logic        starve;
    } exp_t;

    exp_t sb[$];
    exp_t got, e;
    int n_chk = 0, n_pass = 0;
    int m_rr = 0, m_defl = 0, m_sc = 0;

    always #5 clk = ~clk;

    bless_port_alloc dut (
        .clk(clk), .reset(reset), .vld_in(vld_in),
        .ppv_in_0(ppv_in_0), .ppv_in_1(ppv_in_1), .ppv_in_2(ppv_in_2), .ppv_in_3(ppv_in_3),
        .age_in_0(age_in_0), .age_in_1(age_in_1), .age_in_2(age_in_2), .age_in_3(age_in_3),
        .inj_req(inj_req), .inj_ppv(inj_ppv), .inj_gnt(inj_gnt), .inj_slot(inj_slot),
        .indir_rank0(indir_rank0), .indir_rank1(indir_rank1), .indir_rank2(indir_rank2), .indir_rank3(indir_rank3),
        .allocPV_0(allocPV_0), .allocPV_1(allocPV_1), .allocPV_2(allocPV_2), .allocPV_3(allocPV_3),
        .vld_out(vld_out), .defl_cnt(defl_cnt), .starve(starve)
    );

    function automatic exp_t observed();
        return {indir_rank3, indir_rank2, indir_rank1, indir_rank0,
                allocPV_3, allocPV_2, allocPV_1, allocPV_0, vld_out, defl_cnt, starve};
    endfunction

    // Reference model: selection sort in rotated order, then greedy port pick.
    task automatic predict(input logic rst, input logic [3:0] v, input logic [15:0] p,
                           input logic [31:0] a, input logic ir, input logic [3:0] ip);
        exp_t x;
        int ord[4], ea[4];
        bit used[4], ev[4];
        logic [3:0] ep[4];
        logic [3:0] free;
        int nd, best, c, pp, slot;
        bit any;
        x = '0;
        if (rst) begin
            m_rr = 0; m_defl = 0; m_sc = 0;
            x.ranks = 8'he4;
            sb.push_back(x);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            ev[i] = v[i];
            ep[i] = p[4*i +: 4];
            ea[i] = v[i] ? int'(a[8*i +: 8]) : 0;
            used[i] = 0;
        end
        if (ir && v != 4'hf) begin
            slot = 0;
            while (v[slot]) slot++;
            ev[slot] = 1; ep[slot] = ip; ea[slot] = 0;
            m_sc = 0;
        end else
            m_sc = ir ? ((m_sc < 16) ? m_sc + 1 : 16) : 0;
        for (int k = 0; k < 4; k++) begin
            best = -1;
            for (int t = 0; t < 4; t++) begin
                c = (m_rr + t) % 4;
                if (!used[c] && (best < 0 || (ev[c] && !ev[best]) || (ev[c] && ev[best] && ea[c] > ea[best])))
                    best = c;
            end
            used[best] = 1;
            ord[k] = best;
        end
        free = 4'hf; nd = 0; any = 0;
        for (int k = 0; k < 4; k++) begin
            c = ord[k];
            x.ranks[2*k +: 2] = 2'(c);
            if (ev[c]) begin
                any = 1;
                pp = -1;
                for (int q = 0; q < 4; q++) if (pp < 0 && ep[c][q] && free[q]) pp = q;
                if (pp < 0) begin
                    nd++;
                    for (int q = 0; q < 4; q++) if (pp < 0 && free[q]) pp = q;
                end
                free[pp] = 1'b0;
                x.allocs[4*k + pp] = 1'b1;
            end
        end
        x.vo = ~free;
        m_defl = (m_defl + nd > 65535) ? 65535 : m_defl + nd;
        x.defl = 16'(m_defl);
        if (any) m_rr = (m_rr + 1) % 4;
        x.starve = (m_sc >= 16);
        sb.push_back(x);
    endtask

    task automatic drive(input logic rst, input logic [3:0] v, input logic [15:0] p,
                         input logic [31:0] a, input logic ir, input logic [3:0] ip);
        reset = rst; vld_in = v; inj_req = ir; inj_ppv = ip;
        {ppv_in_3, ppv_in_2, ppv_in_1, ppv_in_0} = p;
        {age_in_3, age_in_2, age_in_1, age_in_0} = a;
        predict(rst, v, p, a, ir, ip);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 4'h0, 16'h1248, $urandom, 1, 4'h1);
        #1;
        n_chk++; if (inj_gnt !== 1'b0) $display("FAIL reset_gnt got=%b exp=0", inj_gnt); else n_pass++;
        tick();
        got = observed(); e = sb.pop_front();
        n_chk++; if (got !== e) $display("FAIL reset_sb got=%h exp=%h", got, e); else n_pass++;
    endtask

    task automatic test_single();
        drive(0, 4'b0001, 16'h0004, 32'h5, 0, 4'h0);
        tick();
        got = observed(); e = sb.pop_front();
        n_chk++; if (got !== e) $display("FAIL single_sb got=%h exp=%h", got, e); else n_pass++;
        n_chk++; if (allocPV_0 !== 4'b0100 || vld_out !== 4'b0100) $display("FAIL single_port got=%b/%b exp=0100/0100", allocPV_0, vld_out); else n_pass++;
        n_chk++; if ({allocPV_3, allocPV_2, allocPV_1} !== 12'h0 || indir_rank0 !== 2'd0) $display("FAIL single_rest got=%h r0=%0d exp=0 r0=0", {allocPV_3, allocPV_2, allocPV_1}, indir_rank0); else n_pass++;
    endtask

    task automatic test_conflict();
        int d0;
        d0 = m_defl;
        drive(0, 4'b0011, 16'h0011, 32'h0000_0903, 0, 4'h0);
        tick();
        got = observed(); e = sb.pop_front();
        n_chk++; if (got !== e) $display("FAIL conflict_sb got=%h exp=%h", got, e); else n_pass++;
        n_chk++; if ({indir_rank1, indir_rank0, allocPV_1, allocPV_0} !== {2'd0, 2'd1, 4'b0010, 4'b0001}) $display("FAIL conflict_alloc got=%0d,%0d %b,%b exp=1,0 0001,0010", indir_rank0, indir_rank1, allocPV_0, allocPV_1); else n_pass++;
        n_chk++; if (defl_cnt !== 16'(d0 + 1)) $display("FAIL conflict_defl got=%0d exp=%0d", defl_cnt, d0 + 1); else n_pass++;
    endtask

    task automatic test_tie_rotation();
        drive(1, 4'h0, 16'h0, 32'h0, 0, 4'h0);
        tick();
        got = observed(); e = sb.pop_front();
        n_chk++; if (got !== e) $display("FAIL tie_reset_sb got=%h exp=%h", got, e); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive(0, 4'hf, 16'h1111, 32'h0707_0707, 0, 4'h0);
            tick();
            got = observed(); e = sb.pop_front();
            n_chk++; if (got !== e) $display("FAIL tie_sb%0d got=%h exp=%h", i, got, e); else n_pass++;
            n_chk++; if (indir_rank0 !== 2'(i) || defl_cnt !== 16'(3 * (i + 1))) $display("FAIL tie_rank%0d got=%0d/%0d exp=%0d/%0d", i, indir_rank0, defl_cnt, i, 3 * (i + 1)); else n_pass++;
            n_chk++; if (!($countones(allocPV_0) == 1 && $countones(allocPV_1) == 1 && $countones(allocPV_2) == 1 && $countones(allocPV_3) == 1 && (allocPV_0 | allocPV_1 | allocPV_2 | allocPV_3) == 4'hf))
                $display("FAIL tie_perm%0d got=%b %b %b %b exp=one-hot permutation", i, allocPV_0, allocPV_1, allocPV_2, allocPV_3); else n_pass++;
        end
    endtask

    task automatic test_injection();
        drive(0, 4'b1011, 16'h4021, 32'h1E00_140A, 1, 4'h8);
        #1;
        n_chk++; if (inj_gnt !== 1'b1 || inj_slot !== 2'd2) $display("FAIL inj_grant got=%b/%0d exp=1/2", inj_gnt, inj_slot); else n_pass++;
        tick();
        got = observed(); e = sb.pop_front();
        n_chk++; if (got !== e) $display("FAIL inj_sb got=%h exp=%h", got, e); else n_pass++;
        n_chk++; if (allocPV_3 !== 4'b1000 || indir_rank3 !== 2'd2) $display("FAIL inj_last got=%b/%0d exp=1000/2", allocPV_3, indir_rank3); else n_pass++;
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 17; i++) begin
            drive(0, 4'hf, 16'h1248, $urandom, 1, 4'h1);
            #1;
            n_chk++; if (inj_gnt !== 1'b0) $display("FAIL starve_gnt%0d got=%b exp=0", i, inj_gnt); else n_pass++;
            tick();
            got = observed(); e = sb.pop_front();
            n_chk++; if (got !== e) $display("FAIL starve_sb%0d got=%h exp=%h", i, got, e); else n_pass++;
            if (i == 14) begin n_chk++; if (starve !== 1'b0) $display("FAIL starve_early got=%b exp=0", starve); else n_pass++; end
            if (i == 15) begin n_chk++; if (starve !== 1'b1) $display("FAIL starve_rise got=%b exp=1", starve); else n_pass++; end
        end
        drive(0, 4'b0111, 16'h0248, $urandom, 1, 4'h8);
        #1;
        n_chk++; if (inj_gnt !== 1'b1 || inj_slot !== 2'd3) $display("FAIL starve_relief got=%b/%0d exp=1/3", inj_gnt, inj_slot); else n_pass++;
        tick();
        got = observed(); e = sb.pop_front();
        n_chk++; if (got !== e) $display("FAIL starve_clr_sb got=%h exp=%h", got, e); else n_pass++;
        n_chk++; if (starve !== 1'b0) $display("FAIL starve_fall got=%b exp=0", starve); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(1, 4'h0, 16'h0, 32'h0, 0, 4'h0);
        tick();
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'b0011, 16'h0011, $urandom, 0, 4'h0);
            tick();
            got = observed(); e = sb.pop_front();
            n_chk++; if (got !== e) $display("FAIL mid_sb%0d got=%h exp=%h", i, got, e); else n_pass++;
        end
        n_chk++; if (defl_cnt !== 16'd5) $display("FAIL mid_defl5 got=%0d exp=5", defl_cnt); else n_pass++;
        drive(1, 4'hf, 16'h1111, $urandom, 1, 4'h1);
        tick();
        got = observed(); e = sb.pop_front();
        n_chk++; if (got !== e) $display("FAIL mid_reset_sb got=%h exp=%h", got, e); else n_pass++;
        n_chk++; if ({indir_rank3, indir_rank2, indir_rank1, indir_rank0} !== 8'he4 || vld_out !== 4'h0 || defl_cnt !== 16'h0)
            $display("FAIL mid_reset_state got=%h/%b/%0d exp=e4/0000/0", {indir_rank3, indir_rank2, indir_rank1, indir_rank0}, vld_out, defl_cnt); else n_pass++;
        drive(0, 4'hf, 16'h1111, 32'h0707_0707, 0, 4'h0);
        tick();
        got = observed(); e = sb.pop_front();
        n_chk++; if (got !== e) $display("FAIL mid_tie_sb got=%h exp=%h", got, e); else n_pass++;
        n_chk++; if (indir_rank0 !== 2'd0) $display("FAIL mid_tie_rank got=%0d exp=0", indir_rank0); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) == 0), 4'($urandom), 16'($urandom), $urandom, 1'($urandom), 4'($urandom));
            tick();
            got = observed(); e = sb.pop_front();
            n_chk++; if (got !== e) $display("FAIL random_sb%0d got=%h exp=%h", i, got, e); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        drive(1, 4'h0, 16'h0, 32'h0, 0, 4'h0);
        tick();
        void'(sb.pop_front());
        for (int i = 0; i < 16390; i++) begin
            drive(0, 4'hf, 16'h0, $urandom, 0, 4'h0);
            tick();
            got = observed(); e = sb.pop_front();
            n_chk++; if (got !== e) $display("FAIL sat_sb%0d got=%h exp=%h", i, got, e); else n_pass++;
        end
        n_chk++; if (defl_cnt !== 16'hffff) $display("FAIL sat_hold got=%h exp=ffff", defl_cnt); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; vld_in = '0; inj_req = 1'b0; inj_ppv = '0;
        {ppv_in_3, ppv_in_2, ppv_in_1, ppv_in_0} = '0;
        {age_in_3, age_in_2, age_in_1, age_in_0} = '0;
        test_reset();
        test_single();
        test_conflict();
        test_tie_rotation();
        test_injection();
        test_starvation();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
